wb_grf: RTL and testbench

WB_GRF -- requirements
Module: wb_grf

---
 rtl/wb_grf_if.sv | 35 +++
 rtl/wb_grf.sv | 113 +++++++++++
 tb/tb_wb_grf.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_grf_if.sv
// Write-back / register-file bus: write-back request, read ports and commit trace.
// The master side (pipeline) drives requests; the slave side (wb_grf) answers.
interface wb_grf_if;
    logic [4:0]  RegSelectedIN;
    logic [31:0] aluResultIN;
    logic [31:0] RDIN;
    logic [31:0] PCplus8IN;
    logic        MemtoRegIN;
    logic        RegWriteIN;
    logic        isjalIN;
    logic [31:0] PCIN;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        TraceValidOUT;
    logic [31:0] TracePCOUT;
    logic [4:0]  TraceRegOUT;
    logic [31:0] TraceDataOUT;
    logic [31:0] WBCountOUT;

    modport master (
        output RegSelectedIN, aluResultIN, RDIN, PCplus8IN, MemtoRegIN,
               RegWriteIN, isjalIN, PCIN, A1, A2,
        input  RD1, RD2, TraceValidOUT, TracePCOUT, TraceRegOUT,
               TraceDataOUT, WBCountOUT
    );

    modport slave (
        input  RegSelectedIN, aluResultIN, RDIN, PCplus8IN, MemtoRegIN,
               RegWriteIN, isjalIN, PCIN, A1, A2,
        output RD1, RD2, TraceValidOUT, TracePCOUT, TraceRegOUT,
               TraceDataOUT, WBCountOUT
    );
endinterface

// File: rtl/wb_grf.sv
// 32x32 general register file with write-back data select, write-first bypass,
// registered commit trace and a committed-write counter.
module wb_grf (
    input  logic      clk,
    input  logic      reset,
    wb_grf_if.slave   bus
);

    logic [31:0] regs_r [32];
    logic        commit_s;
    logic [31:0] wdata_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;
    logic        trace_valid_r;
    logic [31:0] trace_pc_r;
    logic [4:0]  trace_reg_r;
    logic [31:0] trace_data_r;
    logic [31:0] wb_count_r;

    // Link address beats load data, load data beats ALU result.
    function automatic logic [31:0] select_wdata(
        input logic        isjal,
        input logic        memtoreg,
        input logic [31:0] pc8,
        input logic [31:0] rd,
        input logic [31:0] alu
    );
        logic [31:0] res;
        if (isjal) begin
            res = pc8;
        end else if (memtoreg) begin
            res = rd;
        end else begin
            res = alu;
        end
        return res;
    endfunction

    // Write-data select and commit qualification.
    always_comb begin
        wdata_s  = select_wdata(bus.isjalIN, bus.MemtoRegIN, bus.PCplus8IN,
                                bus.RDIN, bus.aluResultIN);
        commit_s = 1'b0;
        if (!reset && bus.RegWriteIN && (bus.RegSelectedIN != 5'd0)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Read port 1 with write-first bypass; zero during reset and for r0.
    always_comb begin
        rd1_s = 32'd0;
        if (reset || (bus.A1 == 5'd0)) begin
            rd1_s = 32'd0;
        end else if (commit_s && (bus.A1 == bus.RegSelectedIN)) begin
            rd1_s = wdata_s;
        end else begin
            rd1_s = regs_r[bus.A1];
        end
    end

    // Read port 2, independent of port 1.
    always_comb begin
        rd2_s = 32'd0;
        if (reset || (bus.A2 == 5'd0)) begin
            rd2_s = 32'd0;
        end else if (commit_s && (bus.A2 == bus.RegSelectedIN)) begin
            rd2_s = wdata_s;
        end else begin
            rd2_s = regs_r[bus.A2];
        end
    end

    // Register array storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (commit_s) begin
            regs_r[bus.RegSelectedIN] <= wdata_s;
        end
    end

    // Commit trace and write counter; fields other than valid hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid_r <= 1'b0;
            trace_pc_r    <= 32'd0;
            trace_reg_r   <= 5'd0;
            trace_data_r  <= 32'd0;
            wb_count_r    <= 32'd0;
        end else if (commit_s) begin
            trace_valid_r <= 1'b1;
            trace_pc_r    <= bus.PCIN;
            trace_reg_r   <= bus.RegSelectedIN;
            trace_data_r  <= wdata_s;
            wb_count_r    <= wb_count_r + 32'd1;
        end else begin
            trace_valid_r <= 1'b0;
        end
    end

    assign bus.RD1           = rd1_s;
    assign bus.RD2           = rd2_s;
    assign bus.TraceValidOUT = trace_valid_r;
    assign bus.TracePCOUT    = trace_pc_r;
    assign bus.TraceRegOUT   = trace_reg_r;
    assign bus.TraceDataOUT  = trace_data_r;
    assign bus.WBCountOUT    = wb_count_r;

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: expectations are queued as stimulus is driven
// and drained against the DUT outputs at the matching sample point.
module tb_wb_grf;

    typedef enum logic [2:0] {S_RD1, S_RD2, S_TV, S_TPC, S_TREG, S_TDATA, S_CNT} sig_e;
    typedef struct {
        string       tag;
        sig_e        sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    wb_grf_if bus ();

    exp_t        exp_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [31:0] m_wd;
    logic        m_commit;

    wb_grf dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sig_e s);
        logic [31:0] v;
        case (s)
            S_RD1:   v = bus.RD1;
            S_RD2:   v = bus.RD2;
            S_TV:    v = {31'd0, bus.TraceValidOUT};
            S_TPC:   v = bus.TracePCOUT;
            S_TREG:  v = {27'd0, bus.TraceRegOUT};
            S_TDATA: v = bus.TraceDataOUT;
            S_CNT:   v = bus.WBCountOUT;
            default: v = 32'hxxxxxxxx;
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input sig_e s, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic we, input logic [4:0] sel, input logic [31:0] alu,
                      input logic [31:0] rd, input logic [31:0] pc8, input logic mtr,
                      input logic jal, input logic [31:0] pc);
        bus.RegWriteIN    = we;
        bus.RegSelectedIN = sel;
        bus.aluResultIN   = alu;
        bus.RDIN          = rd;
        bus.PCplus8IN     = pc8;
        bus.MemtoRegIN    = mtr;
        bus.isjalIN       = jal;
        bus.PCIN          = pc;
    endtask

    task automatic idle();
        bus.RegWriteIN = 1'b0;
        bus.MemtoRegIN = 1'b0;
        bus.isjalIN    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        wr(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        bus.A1 = 5'd0;
        bus.A2 = 5'd0;
        tick();

        // Reset state
        reset  = 1'b0;
        bus.A1 = 5'd5;
        bus.A2 = 5'd31;
        push("rst_rd1", S_RD1, 32'd0);
        push("rst_rd2", S_RD2, 32'd0);
        push("rst_cnt", S_CNT, 32'd0);
        push("rst_tv", S_TV, 32'd0);
        push("rst_tpc", S_TPC, 32'd0);
        drain();

        // ALU write to r8, observed the following cycle
        wr(1'b1, 5'd8, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3000);
        tick();
        idle();
        bus.A1 = 5'd8;
        push("alu_rd1", S_RD1, 32'h1234);
        push("alu_tv", S_TV, 32'd1);
        push("alu_treg", S_TREG, 32'd8);
        push("alu_tpc", S_TPC, 32'h3000);
        push("alu_tdata", S_TDATA, 32'h1234);
        push("alu_cnt", S_CNT, 32'd1);
        drain();

        // jal beats MemtoReg; both ports bypass the same register
        wr(1'b1, 5'd31, 32'h77, 32'hDEAD, 32'h3010, 1'b1, 1'b1, 32'h3008);
        bus.A1 = 5'd31;
        bus.A2 = 5'd31;
        push("byp_rd2", S_RD2, 32'h3010);
        push("byp_rd1", S_RD1, 32'h3010);
        drain();
        tick();
        idle();
        push("jal_rd2", S_RD2, 32'h3010);
        push("jal_tv", S_TV, 32'd1);
        push("jal_treg", S_TREG, 32'd31);
        push("jal_tdata", S_TDATA, 32'h3010);
        push("jal_cnt", S_CNT, 32'd2);
        drain();

        // Write to r0 is dropped
        wr(1'b1, 5'd0, 32'hFFFF, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3020);
        bus.A1 = 5'd0;
        push("r0_rd1", S_RD1, 32'd0);
        drain();
        tick();
        idle();
        push("r0_tv", S_TV, 32'd0);
        push("r0_cnt", S_CNT, 32'd2);
        push("r0_treg_hold", S_TREG, 32'd31);
        push("r0_tpc_hold", S_TPC, 32'h3008);
        drain();

        // Load to r3, then reset the next cycle with a write presented
        wr(1'b1, 5'd3, 32'h0, 32'hCAFE, 32'h0, 1'b1, 1'b0, 32'h3030);
        tick();
        reset = 1'b1;
        wr(1'b1, 5'd4, 32'hBEEF, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3034);
        bus.A1 = 5'd3;
        bus.A2 = 5'd4;
        push("rstmid_rd1", S_RD1, 32'd0);
        push("rstmid_rd2", S_RD2, 32'd0);
        push("rstmid_tv_pre", S_TV, 32'd1);
        drain();
        tick();
        reset = 1'b0;
        idle();
        push("rstmid_tv", S_TV, 32'd0);
        push("rstmid_cnt", S_CNT, 32'd0);
        push("rstmid_r3", S_RD1, 32'd0);
        push("rstmid_r4", S_RD2, 32'd0);
        push("rstmid_tdata", S_TDATA, 32'd0);
        push("rstmid_treg", S_TREG, 32'd0);
        drain();

        // Counter wrap
        force dut.wb_count_r = 32'hFFFFFFFF;
        #1;
        release dut.wb_count_r;
        push("wrap_pre", S_CNT, 32'hFFFFFFFF);
        drain();
        wr(1'b1, 5'd9, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3040);
        tick();
        idle();
        bus.A1 = 5'd9;
        push("wrap_cnt", S_CNT, 32'd0);
        push("wrap_rd1", S_RD1, 32'h55);
        drain();

        // Back-to-back writes to the same register
        for (int i = 0; i < 3; i++) begin
            wr(1'b1, 5'd7, 32'd100 + 32'(i), 32'h0, 32'h0, 1'b0, 1'b0, 32'h4000 + 32'(4 * i));
            bus.A1 = 5'd7;
            push("b2b_byp", S_RD1, 32'd100 + 32'(i));
            drain();
            tick();
            push("b2b_tv", S_TV, 32'd1);
            push("b2b_tdata", S_TDATA, 32'd100 + 32'(i));
            push("b2b_tpc", S_TPC, 32'h4000 + 32'(4 * i));
            push("b2b_cnt", S_CNT, 32'd1 + 32'(i));
        end
        idle();
        push("b2b_final", S_RD1, 32'd102);
        drain();

        // Randomised phase against a reference model, from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        for (int n = 0; n < 80; n++) begin
            wr(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
               $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               $urandom());
            bus.A1 = ($urandom_range(0, 1) == 1) ? bus.RegSelectedIN : 5'($urandom_range(0, 31));
            bus.A2 = 5'($urandom_range(0, 31));
            m_wd = bus.isjalIN ? bus.PCplus8IN : (bus.MemtoRegIN ? bus.RDIN : bus.aluResultIN);
            m_commit = bus.RegWriteIN && (bus.RegSelectedIN != 5'd0);
            push("rnd_rd1", S_RD1, (m_commit && bus.A1 == bus.RegSelectedIN) ? m_wd : m_regs[bus.A1]);
            push("rnd_rd2", S_RD2, (m_commit && bus.A2 == bus.RegSelectedIN) ? m_wd : m_regs[bus.A2]);
            drain();
            if (m_commit) begin
                m_regs[bus.RegSelectedIN] = m_wd;
                m_cnt = m_cnt + 32'd1;
                push("rnd_tdata", S_TDATA, m_wd);
                push("rnd_treg", S_TREG, {27'd0, bus.RegSelectedIN});
                push("rnd_tpc", S_TPC, bus.PCIN);
            end
            push("rnd_tv", S_TV, {31'd0, m_commit});
            push("rnd_cnt", S_CNT, m_cnt);
            tick();
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
